// File: rtl/issue_hazard_ctrl.sv
// ============================================================================
// Module      : issue_hazard_ctrl
// Description : Dual-lane issue/hazard controller between ID and ID/EX with
//               saturating stall and split performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             reloj,
    input  logic             reset_n,
    input  logic             valid1,
    input  logic             valid2,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rt1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rt2,
    input  logic             use_rs1,
    input  logic             use_rt1,
    input  logic             use_rs2,
    input  logic             use_rt2,
    input  logic             wr1,
    input  logic [4:0]       wd1,
    input  logic             ld_exe1,
    input  logic             ld_exe2,
    input  logic [4:0]       ld_rt_exe1,
    input  logic [4:0]       ld_rt_exe2,
    input  logic             br_flush,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             bubble1,
    output logic             bubble2,
    output logic             freeze,
    output logic             in_split,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] split_cnt
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_split_cnt;

    logic w_rs1_hit, w_rt1_hit, w_rs2_hit, w_rt2_hit;
    logic w_lu1, w_lu2, w_dep;
    logic w_pc_en, w_b1, w_b2, w_freeze, w_split_inc;

    // A source register 0 is hardwired to zero and can never hazard.
    assign w_rs1_hit = use_rs1 && (rs1 != 5'd0) &&
                       ((ld_exe1 && (rs1 == ld_rt_exe1)) || (ld_exe2 && (rs1 == ld_rt_exe2)));
    assign w_rt1_hit = use_rt1 && (rt1 != 5'd0) &&
                       ((ld_exe1 && (rt1 == ld_rt_exe1)) || (ld_exe2 && (rt1 == ld_rt_exe2)));
    assign w_rs2_hit = use_rs2 && (rs2 != 5'd0) &&
                       ((ld_exe1 && (rs2 == ld_rt_exe1)) || (ld_exe2 && (rs2 == ld_rt_exe2)));
    assign w_rt2_hit = use_rt2 && (rt2 != 5'd0) &&
                       ((ld_exe1 && (rt2 == ld_rt_exe1)) || (ld_exe2 && (rt2 == ld_rt_exe2)));

    assign w_lu1 = valid1 && (w_rs1_hit || w_rt1_hit);
    assign w_lu2 = valid2 && (w_rs2_hit || w_rt2_hit);
    assign w_dep = valid2 && wr1 && (wd1 != 5'd0) &&
                   ((use_rs2 && (rs2 == wd1)) || (use_rt2 && (rt2 == wd1)));

    always_comb begin
        w_pc_en     = 1'b0;
        w_b1        = 1'b1;
        w_b2        = 1'b1;
        w_freeze    = 1'b0;
        w_next      = r_state;
        w_split_inc = 1'b0;
        if (!reset_n) begin
            w_next = ST_RUN;
        end else if (mem_busy) begin
            w_freeze = 1'b1;
            w_b1     = 1'b0;
            w_b2     = 1'b0;
        end else if (br_flush) begin
            w_pc_en = 1'b1;
            w_next  = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (w_lu1) begin
                w_next = ST_RUN;
            end else if (w_lu2 || w_dep) begin
                w_b1        = ~valid1;
                w_next      = ST_SPLIT;
                w_split_inc = 1'b1;
            end else begin
                w_b1    = ~valid1;
                w_b2    = ~valid2;
                w_pc_en = 1'b1;
            end
        end else begin
            // Lane 1 of the held bundle already issued; only lane 2 remains.
            if (!w_lu2) begin
                w_b2    = ~valid2;
                w_pc_en = 1'b1;
                w_next  = ST_RUN;
            end
        end
    end

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_split_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (clr_cnt) begin
                r_stall_cnt <= '0;
                r_split_cnt <= '0;
            end else begin
                if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (w_split_inc && (r_split_cnt != {CNT_W{1'b1}}))
                    r_split_cnt <= r_split_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en     = w_pc_en;
    assign bubble1   = w_b1;
    assign bubble2   = w_b2;
    assign freeze    = w_freeze;
    assign in_split  = reset_n && (r_state == ST_SPLIT);
    assign stall_cnt = r_stall_cnt;
    assign split_cnt = r_split_cnt;

endmodule

`default_nettype wire

// File: tb/tb_issue_hazard_ctrl.sv
// ============================================================================
// Module      : tb_issue_hazard_ctrl
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_hazard_ctrl;

    typedef struct packed {
        logic       valid1, valid2;
        logic [4:0] rs1, rt1, rs2, rt2;
        logic       use_rs1, use_rt1, use_rs2, use_rt2;
        logic       wr1;
        logic [4:0] wd1;
        logic       ld_exe1, ld_exe2;
        logic [4:0] ld_rt_exe1, ld_rt_exe2;
        logic       br_flush, mem_busy, clr_cnt;
    } in_t;

    typedef struct {
        in_t        in;
        logic [4:0] exp_out;   // {pc_en, bubble1, bubble2, freeze, in_split}
        int         exp_stall;
        int         exp_split;
    } vec_t;

    logic        reloj;
    logic        reset_n;
    in_t         cur;
    logic        pc_en, bubble1, bubble2, freeze, in_split;
    logic [15:0] stall_cnt, split_cnt;

    int n_chk = 0;
    int n_err = 0;

    issue_hazard_ctrl #(.CNT_W(16)) dut (
        .reloj(reloj), .reset_n(reset_n),
        .valid1(cur.valid1), .valid2(cur.valid2),
        .rs1(cur.rs1), .rt1(cur.rt1), .rs2(cur.rs2), .rt2(cur.rt2),
        .use_rs1(cur.use_rs1), .use_rt1(cur.use_rt1),
        .use_rs2(cur.use_rs2), .use_rt2(cur.use_rt2),
        .wr1(cur.wr1), .wd1(cur.wd1),
        .ld_exe1(cur.ld_exe1), .ld_exe2(cur.ld_exe2),
        .ld_rt_exe1(cur.ld_rt_exe1), .ld_rt_exe2(cur.ld_rt_exe2),
        .br_flush(cur.br_flush), .mem_busy(cur.mem_busy), .clr_cnt(cur.clr_cnt),
        .pc_en(pc_en), .bubble1(bubble1), .bubble2(bubble2), .freeze(freeze),
        .in_split(in_split), .stall_cnt(stall_cnt), .split_cnt(split_cnt)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    function automatic in_t pk(bit v1, bit v2, int s1, int t1, int s2, int t2,
                               bit [3:0] u, bit w, int d, bit le1, bit le2,
                               int lr1, int lr2, bit fl, bit busy, bit clr);
        in_t x;
        x.valid1 = v1; x.valid2 = v2;
        x.rs1 = 5'(s1); x.rt1 = 5'(t1); x.rs2 = 5'(s2); x.rt2 = 5'(t2);
        {x.use_rs1, x.use_rt1, x.use_rs2, x.use_rt2} = u;
        x.wr1 = w; x.wd1 = 5'(d);
        x.ld_exe1 = le1; x.ld_exe2 = le2;
        x.ld_rt_exe1 = 5'(lr1); x.ld_rt_exe2 = 5'(lr2);
        x.br_flush = fl; x.mem_busy = busy; x.clr_cnt = clr;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {pc_en, bubble1, bubble2, freeze, in_split};
    endfunction

    // ---------------- behavioural reference model ----------------
    bit m_split;
    int m_stall, m_splits;

    function automatic bit reads(in_t x, bit lane2, logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (!lane2) return (x.use_rs1 && x.rs1 == r) || (x.use_rt1 && x.rt1 == r);
        return (x.use_rs2 && x.rs2 == r) || (x.use_rt2 && x.rt2 == r);
    endfunction

    function automatic bit load_use(in_t x, bit lane2);
        bit v = lane2 ? x.valid2 : x.valid1;
        return v && ((x.ld_exe1 && reads(x, lane2, x.ld_rt_exe1)) ||
                     (x.ld_exe2 && reads(x, lane2, x.ld_rt_exe2)));
    endfunction

    // Returns expected outputs for the current model state and stages the
    // next-state / counter effects into the output arguments.
    task automatic model(in_t x, output logic [4:0] o, output bit nsplit, output bit new_split);
        bit pc, b1, b2, fz;
        bit dep = x.valid2 && x.wr1 && reads(x, 1'b1, x.wd1);
        nsplit = m_split; new_split = 0; fz = 0;
        if (x.mem_busy) begin
            pc = 0; b1 = 0; b2 = 0; fz = 1;
        end else if (x.br_flush) begin
            pc = 1; b1 = 1; b2 = 1; nsplit = 0;
        end else if (!m_split) begin
            if (load_use(x, 0)) begin
                pc = 0; b1 = 1; b2 = 1;
            end else if (load_use(x, 1) || dep) begin
                pc = 0; b1 = !x.valid1; b2 = 1; nsplit = 1; new_split = 1;
            end else begin
                pc = 1; b1 = !x.valid1; b2 = !x.valid2;
            end
        end else begin
            b1 = 1;
            if (load_use(x, 1)) begin
                pc = 0; b2 = 1;
            end else begin
                pc = 1; b2 = !x.valid2; nsplit = 0;
            end
        end
        o = {pc, b1, b2, fz, m_split};
    endtask

    task automatic model_commit(in_t x, logic [4:0] o, bit nsplit, bit new_split);
        m_split = nsplit;
        if (x.clr_cnt) begin
            m_stall = 0; m_splits = 0;
        end else begin
            if (!o[4]) m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
            if (new_split) m_splits = (m_splits + 1 > 65535) ? 65535 : m_splits + 1;
        end
    endtask

    vec_t tbl[18];
    in_t  idle, depl;

    initial begin
        logic [4:0] eo;
        bit         ns, nw;

        idle = pk(0,0, 0,0,0,0, 4'b0000, 0,0, 0,0,0,0, 0,0,0);
        depl = pk(1,1, 1,2,6,4, 4'b0010, 1,6, 0,0,0,0, 0,0,0);

        tbl[0]  = '{pk(1,1, 1,2,3,4, 4'b1111, 1,5, 0,0,0,0, 0,0,0), 5'b10000, 0, 0};
        tbl[1]  = '{pk(1,1, 7,2,3,4, 4'b1000, 0,0, 0,1,0,7, 0,0,0), 5'b01100, 1, 0};
        tbl[2]  = '{pk(1,1, 7,2,3,4, 4'b1000, 0,0, 0,0,0,7, 0,0,0), 5'b10000, 1, 0};
        tbl[3]  = '{pk(1,1, 1,2,3,9, 4'b0001, 1,9, 0,0,0,0, 0,0,0), 5'b00100, 2, 1};
        tbl[4]  = '{pk(1,1, 1,2,3,9, 4'b0001, 1,9, 0,0,0,0, 0,0,0), 5'b11001, 2, 1};
        tbl[5]  = '{depl,                                            5'b00100, 3, 2};
        tbl[6]  = '{pk(1,1, 1,2,6,4, 4'b0010, 1,6, 1,0,6,0, 0,1,0), 5'b00011, 4, 2};
        tbl[7]  = '{pk(1,1, 1,2,6,4, 4'b0010, 1,6, 1,0,6,0, 0,1,0), 5'b00011, 5, 2};
        tbl[8]  = '{pk(1,1, 1,2,6,4, 4'b0010, 1,6, 1,0,6,0, 0,1,0), 5'b00011, 6, 2};
        tbl[9]  = '{pk(1,1, 1,2,6,4, 4'b0010, 1,6, 1,0,6,0, 0,0,0), 5'b01101, 7, 2};
        tbl[10] = '{depl,                                            5'b11001, 7, 2};
        tbl[11] = '{depl,                                            5'b00100, 8, 3};
        tbl[12] = '{pk(1,1, 1,2,6,4, 4'b0010, 1,6, 1,0,6,0, 1,0,0), 5'b11101, 8, 3};
        tbl[13] = '{pk(1,1, 7,2,3,4, 4'b1000, 0,0, 0,1,0,7, 1,0,0), 5'b11100, 8, 3};
        tbl[14] = '{pk(1,0, 1,2,3,4, 4'b1111, 1,5, 0,0,0,0, 0,0,0), 5'b10100, 8, 3};
        tbl[15] = '{pk(1,1, 7,2,3,4, 4'b1000, 0,0, 0,1,0,7, 0,0,1), 5'b01100, 0, 0};
        tbl[16] = '{pk(1,1, 1,2,6,4, 4'b0010, 0,0, 1,0,6,0, 0,1,0), 5'b00010, 1, 0};
        tbl[17] = '{pk(1,1, 0,2,0,4, 4'b1010, 1,0, 1,0,0,0, 0,0,0), 5'b10000, 1, 0};

        // Reset state: idle inputs would otherwise issue.
        cur = idle;
        reset_n = 1'b0;
        repeat (2) @(posedge reloj);
        @(negedge reloj);
        chk("reset_outputs", outs(), 5'b01100);
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_split_cnt", split_cnt, 0);
        reset_n = 1'b1;
        @(posedge reloj); #1;

        // Directed vector table, applied back to back.
        for (int i = 0; i < 18; i++) begin
            cur = tbl[i].in;
            @(negedge reloj);
            chk($sformatf("vec%0d_out", i), outs(), tbl[i].exp_out);
            @(posedge reloj); #1;
            chk($sformatf("vec%0d_stall", i), stall_cnt, tbl[i].exp_stall);
            chk($sformatf("vec%0d_split", i), split_cnt, tbl[i].exp_split);
        end

        // Asynchronous reset asserted mid-SPLIT.
        cur = depl;
        @(posedge reloj); #1;
        chk("pre_reset_in_split", in_split, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 5'b01100);
        chk("async_reset_stall", stall_cnt, 0);
        chk("async_reset_split", split_cnt, 0);
        cur = idle;
        @(negedge reloj);
        reset_n = 1'b1;
        @(posedge reloj); #1;
        chk("post_reset_in_split", in_split, 0);

        // Randomized stimulus against the model.
        m_split = 0; m_stall = 0; m_splits = 0;
        for (int i = 0; i < 3000; i++) begin
            in_t x;
            x = pk($urandom_range(0,7) != 0, $urandom_range(0,7) != 0,
                   $urandom_range(0,3), $urandom_range(0,3),
                   $urandom_range(0,3), $urandom_range(0,3),
                   4'($urandom_range(0,15)), $urandom_range(0,1) == 1,
                   $urandom_range(0,3), $urandom_range(0,1) == 1,
                   $urandom_range(0,1) == 1, $urandom_range(0,3),
                   $urandom_range(0,3), $urandom_range(0,7) == 0,
                   $urandom_range(0,7) == 0, $urandom_range(0,31) == 0);
            cur = x;
            @(negedge reloj);
            model(x, eo, ns, nw);
            chk("rand_out", outs(), eo);
            @(posedge reloj); #1;
            model_commit(x, eo, ns, nw);
            chk("rand_stall", stall_cnt, m_stall);
            chk("rand_split", split_cnt, m_splits);
        end

        // Saturation: 2^16 freeze cycles must stop at all-ones.
        cur = idle;
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        cur.mem_busy = 1'b1;
        repeat (65536) @(posedge reloj);
        #1;
        chk("sat_stall_max", stall_cnt, 16'hFFFF);
        @(posedge reloj); #1;
        chk("sat_stall_hold", stall_cnt, 16'hFFFF);
        cur.clr_cnt = 1'b1;
        @(posedge reloj); #1;
        chk("sat_clear", stall_cnt, 0);
        cur = idle;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
